// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// A 128-bit state is captured on an in_valid/in_ready handshake. LANES bytes are
// substituted per clock, over 16/LANES cycles. The result is then held on nstate
// until it is taken with out_valid/out_ready.
// Optional build macro INV_SUB_BYTES_DUAL_EN adds a mode_fwd input. It is sampled
// at acceptance and selects the forward S-box, so the block can also serve the
// encryption path.

module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef INV_SUB_BYTES_DUAL_EN
    input  logic         mode_fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] nstate,
    output logic         busy
);

    localparam int unsigned NBYTES = 16;
    localparam int unsigned STEPS  = NBYTES / LANES;
    localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Only lane counts that split the state into equal power-of-two steps are legal
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_d;
    logic             out_valid_d;
    logic             busy_d;
    logic             accept_c;
    logic             last_c;
    logic [CNT_W-1:0] cnt_q;
    logic [127:0]     cap_q;
    logic [7:0]       lane_out [LANES];
`ifdef INV_SUB_BYTES_DUAL_EN
    logic             mode_q;
`endif

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x3;
        logic [7:0] x6;
        logic [7:0] x12;
        logic [7:0] x15;
        logic [7:0] x30;
        logic [7:0] x60;
        logic [7:0] x120;
        logic [7:0] x240;
        logic [7:0] x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Inverse affine map: y_i = x_(i+2) ^ x_(i+5) ^ x_(i+7) ^ 0x05_i
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(inv_affine(x));
    endfunction

`ifdef INV_SUB_BYTES_DUAL_EN
    // Forward affine map: y_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ 0x63_i
    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]}
                 ^ {x[6:0], x[7]} ^ 8'h63;
    endfunction

    // Forward S-box: invert in the field, then apply the affine map
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        return fwd_affine(gf_inv(x));
    endfunction
`endif

    // Lane j substitutes captured byte cnt*LANES + j in the current step
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [3:0] idx;
        logic [7:0] lane_in;
        assign idx     = 4'(int'(cnt_q) * int'(LANES) + j);
        assign lane_in = cap_q[{idx, 3'b000} +: 8];
`ifdef INV_SUB_BYTES_DUAL_EN
        assign lane_out[j] = mode_q ? fwd_sbox(lane_in) : inv_sbox(lane_in);
`else
        assign lane_out[j] = inv_sbox(lane_in);
`endif
    end

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        last_c   = (cnt_q == CNT_W'(STEPS - 1));
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Capture the input state on accept and step the byte counter while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= '0;
            cnt_q  <= '0;
`ifdef INV_SUB_BYTES_DUAL_EN
            mode_q <= 1'b0;
`endif
        end else if (accept_c) begin
            cap_q  <= state_in;
            cnt_q  <= '0;
`ifdef INV_SUB_BYTES_DUAL_EN
            mode_q <= mode_fwd;
`endif
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Each result byte is written only in the step that owns it
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam int unsigned STEP = b / LANES;
        localparam int unsigned LANE = b % LANES;
        logic [7:0] res_q;
        // Result byte register
        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= 8'h00;
            end else if (state_q == BUSY && cnt_q == CNT_W'(STEP)) begin
                res_q <= lane_out[LANE];
            end
        end
        assign nstate[b*8 +: 8] = res_q;
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq. Five instances cover LANES = 1, 2, 4, 8 and 16.
// Stimulus pushes expected results into per-instance queues. A monitor on each
// instance pops an entry on every output handshake and checks the latency.
// Define INV_SUB_BYTES_DUAL_EN to also exercise the forward mode.

module tb_inv_sub_bytes_seq;

    localparam int NI = 5;
    typedef logic [2:0] idx_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [NI];
    logic         ir   [NI];
    logic         ov   [NI];
    logic         ordy [NI];
    logic         bsy  [NI];
    logic [127:0] si   [NI];
    logic [127:0] ns   [NI];
`ifdef INV_SUB_BYTES_DUAL_EN
    logic         mf   [NI];
`endif
    logic [127:0] exp_q [NI][$];

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .state_in  (si[k]),
`ifdef INV_SUB_BYTES_DUAL_EN
            .mode_fwd  (mf[k]),
`endif
            .out_valid (ov[k]),
            .out_ready (ordy[k]),
            .nstate    (ns[k]),
            .busy      (bsy[k])
        );

        // Monitor: latency from accept edge to out_valid, and result on each handshake
        initial begin
            logic pend;
            int   lat;
            pend = 1'b0;
            lat  = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    pend = 1'b0;
                end else begin
                    if (pend) begin
                        lat++;
                        if (ov[k]) begin
                            check_int($sformatf("latency_L%0d", 1 << k), lat, 16 >> k);
                            pend = 1'b0;
                        end
                    end
                    if (ov[k] && ordy[k]) begin
                        if (exp_q[k].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_output_L%0d: got %h, expected no output", 1 << k, ns[k]);
                        end else begin
                            check($sformatf("nstate_L%0d", 1 << k), ns[k], exp_q[k].pop_front());
                        end
                    end
                    if (iv[k] && ir[k]) begin
                        pend = 1'b1;
                        lat  = -1;
                    end
                end
            end
        end
    end

    // Present one state and hold in_valid until it is accepted
    task automatic send(input idx_t k, input logic [127:0] d, input logic [127:0] e, input bit push);
        int   guard;
        logic acc;
        guard = 0;
        acc   = 1'b0;
        si[k] = d;
        iv[k] = 1'b1;
        if (push) exp_q[k].push_back(e);
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = iv[k] && ir[k];
            @(posedge clk);
            #1;
            guard++;
        end
        iv[k] = 1'b0;
        si[k] = {$urandom, $urandom, $urandom, $urandom};
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout_idx%0d: got no accept, expected accept within 50 cycles", k);
        end
    endtask

    task automatic wait_idle(input idx_t k);
        int guard;
        guard = 0;
        while (ir[k] !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ir[k] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout_idx%0d: got in_ready %b, expected 1 within 100 cycles", k, ir[k]);
        end
    endtask

    // Forward S-box applied bytewise
    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] t;
        logic [127:0] f;
        t = s;
        f = '0;
        for (int b = 0; b < 16; b++) begin
            f = {SBOX[t[7:0]], f[127:8]};
            t = t >> 8;
        end
        return f;
    endfunction

    initial begin
        idx_t         kk;
        logic [127:0] r;
        logic [127:0] bp_exp;
        int           guard;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            si[k]   = '0;
`ifdef INV_SUB_BYTES_DUAL_EN
            mf[k]   = 1'b0;
`endif
        end

        // Reset state on every instance
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            kk = idx_t'(k);
            check($sformatf("reset_in_ready_L%0d", 1 << k), 128'(ir[kk]), 128'd1);
            check($sformatf("reset_out_valid_L%0d", 1 << k), 128'(ov[kk]), 128'd0);
            check($sformatf("reset_busy_L%0d", 1 << k), 128'(bsy[kk]), 128'd0);
            check($sformatf("reset_nstate_L%0d", 1 << k), ns[kk], 128'd0);
        end
        @(posedge clk);
        #1;

        // Known bytes on LANES=4
        send(3'd2, {{12{8'h00}}, 8'h52, 8'h16, 8'h7c, 8'h63},
                   {{12{8'h52}}, 8'h48, 8'hff, 8'h01, 8'h00}, 1'b1);
        wait_idle(3'd2);

        // Latency sweep with all 0xED
        for (int k = 0; k < NI; k++) begin
            kk = idx_t'(k);
            send(kk, {16{8'hed}}, {16{8'h53}}, 1'b1);
            wait_idle(kk);
        end

        // Backpressure: result held, new input ignored while DONE
        bp_exp = {8{8'h53, 8'h01}};
        ordy[2] = 1'b0;
        send(3'd2, {8{8'hed, 8'h7c}}, bp_exp, 1'b1);
        guard = 0;
        while (ov[2] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_out_valid", 128'(ov[2]), 128'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                iv[2] = 1'b1;
                si[2] = {16{8'h63}};
            end
            if (c == 7) iv[2] = 1'b0;
            @(negedge clk);
            check($sformatf("bp_nstate_c%0d", c), ns[2], bp_exp);
            check($sformatf("bp_in_ready_c%0d", c), 128'(ir[2]), 128'd0);
        end
        @(posedge clk);
        #1 ordy[2] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_after_out_valid", 128'(ov[2]), 128'd0);
        check("bp_after_in_ready", 128'(ir[2]), 128'd1);
        check("bp_after_nstate_kept", ns[2], bp_exp);
        @(posedge clk);
        #1;

        // Reset during the second BUSY cycle on LANES=1
        send(3'd0, {16{8'h52}}, '0, 1'b0);
        @(posedge clk);
        #1;
        check("midop_byte0", 128'(ns[0][7:0]), 128'h48);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midop_in_ready", 128'(ir[0]), 128'd1);
        check("midop_out_valid", 128'(ov[0]), 128'd0);
        check("midop_busy", 128'(bsy[0]), 128'd0);
        check("midop_nstate", ns[0], 128'd0);
        @(posedge clk);
        #1;
        send(3'd0, {16{8'h63}}, 128'd0, 1'b1);
        wait_idle(3'd0);

        // Round trip through the forward table
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(3'd2, fwd_state(r), r, 1'b1);
            wait_idle(3'd2);
        end
        for (int k = 0; k < NI; k++) begin
            kk = idx_t'(k);
            for (int n = 0; n < 6; n++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                send(kk, fwd_state(r), r, 1'b1);
                wait_idle(kk);
            end
        end

`ifdef INV_SUB_BYTES_DUAL_EN
        // Forward mode
        mf[2] = 1'b1;
        send(3'd2, {{14{8'h00}}, 8'h53, 8'h00}, {{14{8'h63}}, 8'hed, 8'h63}, 1'b1);
        mf[2] = 1'b0;
        wait_idle(3'd2);
        mf[0] = 1'b1;
        send(3'd0, {16{8'h53}}, {16{8'hed}}, 1'b1);
        mf[0] = 1'b0;
        wait_idle(3'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            kk = idx_t'(k);
            check_int($sformatf("queue_drained_L%0d", 1 << k), exp_q[kk].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequential AES InvSubBytes engine: applies the FIPS-197 inverse S-box to every byte of a 128-bit state.
- Processes LANES bytes per clock over 16/LANES cycles, with valid/ready handshakes on input and output.
- Sits in the decryption datapath between InvShiftRows and AddRoundKey.
- Trades latency for area against the fully parallel forward SubBytes table.

Parameters:
- LANES, 4, inverse S-box lookups instantiated (bytes processed per cycle). Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  engine can accept a state
- state_in  input  128  byte i = state_in[i*8+:8], i = 0..15
- out_valid  output  1  nstate holds a complete result
- out_ready  input  1  downstream accepts result
- nstate  output  128  byte i = InvSbox(state_in[i*8+:8])
- busy  output  1  high while in BUSY state

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state to IDLE; in_ready=1, out_valid=0, busy=0.
  - nstate=128'h0, byte counter=0, captured state register=0.
  - Reset overrides every other input in the same cycle and aborts any operation in progress. No partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture state_in, clear counter, go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, with k = counter, writes nstate bytes k*LANES .. k*LANES+LANES-1 = InvSbox of the matching captured bytes, then increments counter.
  - Bytes are processed in ascending order, byte 0 first.
  - When counter = 16/LANES-1, go to DONE on that edge.
  - For LANES=16 BUSY lasts exactly 1 cycle.
- DONE:
  - out_valid=1; nstate stable.
  - in_ready=0; in_valid is ignored and state_in is not captured.
  - On out_valid & out_ready: go to IDLE, out_valid=0 on the next cycle. nstate keeps its value until overwritten by the next operation.
- Latency:
  - Accept edge to out_valid high = 16/LANES cycles (LANES=4: 4 cycles).
  - Throughput = one state per 16/LANES+2 cycles when out_ready is held high (1 BUSY entry, N BUSY cycles, 1 DONE handshake cycle).
- No back-to-back acceptance: in_ready is low in the DONE handshake cycle; the next accept happens in IDLE.
- state_in may change after acceptance; only the captured copy is used.
- InvSbox must be exactly the FIPS-197 inverse table, i.e. InvSbox(Sbox(x)) = x for all 256 x. Either a 256-entry case table or GF(2^8) inversion with the inverse affine transform is acceptable. The block is purely byte-wise, with no carries or width growth.
- out_ready held high before out_valid rises has no effect until DONE.

Optional Feature:
- Macro: INV_SUB_BYTES_DUAL_EN
- Defined:
  - Adds port mode_fwd (input, 1), sampled together with state_in at acceptance and held for the operation.
  - mode_fwd=1: each lane uses the forward AES S-box, so the block can serve the encryption path.
  - mode_fwd=0: inverse S-box.
  - Timing and handshakes are identical in both modes.
- Not defined:
  - No mode_fwd port; inverse S-box only; no forward table logic synthesised.

Test Plan:
1. Reset then idle: assert rst 2 cycles -> in_ready=1, out_valid=0, busy=0, nstate=0.
2. Known bytes, LANES=4: state_in=128'h...0052_16_7C_63 (byte0=63, byte1=7C, byte2=16, byte3=52, others 0x00) -> after 4 cycles out_valid=1; byte0=00, byte1=01, byte2=FF, byte3=48, bytes 4..15=52.
3. Latency sweep: for LANES=1,2,4,8,16, state_in of all 0xED -> out_valid rises exactly 16,8,4,2,1 cycles after accept; all bytes 0x53.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> nstate stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> one-cycle handshake, then IDLE.
5. Reset mid-operation: assert rst during cycle 2 of BUSY (LANES=1) -> next cycle IDLE, out_valid=0, nstate=0. The next accepted state of all 0x63 returns all 0x00.
6. Round trip: 1000 random states passed through a forward S-box model, then the DUT -> output equals the original state. With INV_SUB_BYTES_DUAL_EN and mode_fwd=1: byte 0x00 -> 0x63, 0x53 -> 0xED.
